dpd_adapt_ctrl: RTL and testbench
=================================

// Module: dpd_adapt_ctrl
// PURPOSE
//  Sequencer for the DPD LMS adaptation. On a start request it drives
//  repeated dpd_adapt bursts into the dpd core, then lets the loop settle.
//  After each burst it averages err_fit_mag and compares the average to a
//  threshold. It stops when converged or when the iteration budget is spent.
//  Sits between the host/control register block and the dpd core.
// PARAMETERS
//  W          20    width of err_fit_mag, err_thr, err_avg
//  ADAPT_LEN  1024  cycles dpd_adapt held high per burst; must be > DELAY+800 of dpd core
//  SETTLE_LEN 64    cycles dpd_adapt held low before measuring; >=2 so the core sees a fresh edge
//  MEAS_LOG2  6     log2 of averaged error samples per iteration
//  MAX_ITER   8     max bursts per run, 1..15
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous reset, active-high
//  start          in   1   run request, sampled only in IDLE
//  abort          in   1   stop the run immediately
//  err_thr        in   W   convergence threshold, sampled on accepted start
//  err_fit_mag    in   W   error magnitude from dpd core, unsigned
//  dpd_adapt      out  1   adaptation enable to dpd core
//  busy           out  1   run in progress
//  done           out  1   one-cycle pulse at end of a completed run
//  converged      out  1   1 = last run met threshold; held until next start
//  iter           out  4   bursts completed in current/last run
//  err_avg        out  W   latest averaged error; held until next start
//  err_avg_vld    out  1   one-cycle pulse when err_avg updates
// BEHAVIOUR
//  - All outputs are registered. Reset clears every output to 0 and forces state IDLE.
//  - States: IDLE -> ADAPT -> SETTLE -> MEAS -> EVAL -> (ADAPT | DONE) -> IDLE.
//  - IDLE: when start=1 and abort=0, latch err_thr and clear iter, converged and err_avg.
//    Next cycle is ADAPT. start is ignored in every other state.
//  - ADAPT: dpd_adapt=1 for exactly ADAPT_LEN cycles, then SETTLE.
//  - SETTLE: dpd_adapt=0 for SETTLE_LEN cycles, then MEAS.
//  - MEAS: accumulate err_fit_mag for 2^MEAS_LOG2 cycles into a W+MEAS_LOG2 bit unsigned
//    accumulator. The accumulator cannot overflow. On entry to EVAL,
//    err_avg = acc >> MEAS_LOG2 (truncate) and err_avg_vld pulses.
//  - EVAL (1 cycle): iter += 1.
//    If err_avg <= thr: converged=1 -> DONE.
//    Else if iter == MAX_ITER: converged=0 -> DONE.
//    Else -> ADAPT.
//  - DONE (1 cycle): done=1, then IDLE.
//  - busy=1 in every state except IDLE, including DONE.
//  - Cycle 0 = cycle where start is accepted. First burst: dpd_adapt high cycles 1..ADAPT_LEN.
//    done at cycle ADAPT_LEN+SETTLE_LEN+2^MEAS_LOG2+2.
//  - abort in any non-IDLE state: next cycle IDLE, dpd_adapt=0, busy=0, converged=0.
//    No done pulse. iter and err_avg keep their values.
//  - abort and start in the same cycle in IDLE: abort wins, stay IDLE.
//  - Asynchronous reset mid-run: immediate IDLE, all outputs 0. No done pulse.
//  - Counters do not wrap: every phase counter is cleared on phase entry.
// TESTING (bench params: ADAPT_LEN=16 SETTLE_LEN=4 MEAS_LOG2=2 MAX_ITER=3 W=20)
//  1. Reset asserted, then released -> all outputs 0, no activity without start.
//  2. start at cycle 0, err_fit_mag=100, err_thr=200 -> dpd_adapt high cycles 1..16;
//     err_avg=100 with err_avg_vld pulse; iter=1, converged=1, done pulse at cycle 26,
//     busy high cycles 1..26.
//  3. err_fit_mag=500, err_thr=200 -> 3 bursts, each followed by a low gap >=4 cycles;
//     iter=3, converged=0, err_avg=500, single done pulse.
//  4. err_fit_mag = 10,20,30,41 across the MEAS window -> err_avg=25 (101>>2 truncated).
//  5. abort at cycle 8 of a run -> dpd_adapt=0 and busy=0 from cycle 9, no done pulse.
//     A new start then runs normally.
//  6. start pulses during busy are ignored; start+abort in the same cycle in IDLE ->
//     stays IDLE. Reset asserted mid-MEAS -> all outputs 0 immediately.

Source files
------------

// File: rtl/dpd_adapt_ctrl.sv
// DPD LMS adaptation sequencer: bursts dpd_adapt, lets the loop settle, averages
// err_fit_mag, and repeats until the average meets err_thr or the budget runs out.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_ADAPT  | dpd_adapt high, ADAPT_LEN cycles
// S_SETTLE | dpd_adapt low, SETTLE_LEN cycles
// S_MEAS   | accumulate err_fit_mag, 2^MEAS_LOG2 cycles
// S_EVAL   | bump iter, decide converge / retry / give up
// S_DONE   | one-cycle done pulse
module dpd_adapt_ctrl #(
  parameter int W          = 20,
  parameter int ADAPT_LEN  = 1024,
  parameter int SETTLE_LEN = 64,
  parameter int MEAS_LOG2  = 6,
  parameter int MAX_ITER   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] err_thr,
  input  logic [W-1:0] err_fit_mag,
  output logic         dpd_adapt,
  output logic         busy,
  output logic         done,
  output logic         converged,
  output logic [3:0]   iter,
  output logic [W-1:0] err_avg,
  output logic         err_avg_vld
);

  localparam int MEAS_LEN = 1 << MEAS_LOG2;
  localparam int LEN_AB   = (ADAPT_LEN > SETTLE_LEN) ? ADAPT_LEN : SETTLE_LEN;
  localparam int LEN_MAX  = (LEN_AB > MEAS_LEN) ? LEN_AB : MEAS_LEN;
  localparam int CW       = (LEN_MAX > 2) ? $clog2(LEN_MAX) : 1;
  localparam int AW       = W + MEAS_LOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_ADAPT, S_SETTLE, S_MEAS, S_EVAL, S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  acc_sum;
  logic [W-1:0]   thr_q;
  logic [3:0]     iter_inc;
  logic           accept;
  logic           abort_run;
  logic           meets_thr;

  assign acc_sum   = acc + AW'(err_fit_mag);
  assign iter_inc  = iter + 4'd1;
  assign accept    = (state == S_IDLE) && start && !abort;
  assign abort_run = (state != S_IDLE) && abort;
  assign meets_thr = (err_avg <= thr_q);

  // Phase timers are down-counters reloaded on every phase entry, so they never wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_ADAPT;
          cnt_nxt   = CW'(ADAPT_LEN - 1);
        end
      end
      S_ADAPT: begin
        if (cnt == '0) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = CW'(SETTLE_LEN - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = S_MEAS;
          cnt_nxt   = CW'(MEAS_LEN - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_MEAS: begin
        if (cnt == '0) begin
          state_nxt = S_EVAL;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_EVAL: begin
        if (meets_thr || (iter_inc == 4'(MAX_ITER))) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_ADAPT;
          cnt_nxt   = CW'(ADAPT_LEN - 1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_run) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc         <= '0;
      thr_q       <= '0;
      dpd_adapt   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      iter        <= '0;
      err_avg     <= '0;
      err_avg_vld <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      dpd_adapt   <= (state_nxt == S_ADAPT);
      busy        <= (state_nxt != S_IDLE);
      done        <= (state_nxt == S_DONE);
      err_avg_vld <= (state == S_MEAS) && (state_nxt == S_EVAL);

      if (accept) begin
        thr_q     <= err_thr;
        iter      <= '0;
        converged <= 1'b0;
        err_avg   <= '0;
      end

      if (state == S_SETTLE) begin
        acc <= '0;
      end

      if (state == S_MEAS) begin
        acc <= acc_sum;
        if (state_nxt == S_EVAL) begin
          err_avg <= W'(acc_sum >> MEAS_LOG2);
        end
      end

      if ((state == S_EVAL) && !abort) begin
        iter      <= iter_inc;
        converged <= meets_thr;
      end

      if (abort_run) begin
        converged <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dpd_adapt_ctrl.sv
// Directed bench for dpd_adapt_ctrl: table of whole-run vectors plus hand-written
// sequences for averaging, abort, ignored start and mid-run reset.
module tb_dpd_adapt_ctrl;

  localparam int W = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  err_thr;
  logic [W-1:0]  err_fit_mag;
  logic          dpd_adapt;
  logic          busy;
  logic          done;
  logic          converged;
  logic [3:0]    iter;
  logic [W-1:0]  err_avg;
  logic          err_avg_vld;

  int errors = 0;
  int checks = 0;

  dpd_adapt_ctrl #(
    .W(W), .ADAPT_LEN(16), .SETTLE_LEN(4), .MEAS_LOG2(2), .MAX_ITER(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .err_thr(err_thr), .err_fit_mag(err_fit_mag),
    .dpd_adapt(dpd_adapt), .busy(busy), .done(done), .converged(converged),
    .iter(iter), .err_avg(err_avg), .err_avg_vld(err_avg_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] err;
    logic [W-1:0] thr;
    int           n_iter;
    int           conv;
    int           done_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n_adapt = 0, n_busy = 0, n_done = 0, n_vld = 0;
    int done_cyc = 0, first_adapt = 0, first_fall = 0;
    int gap = 0, min_gap = 999;
    logic prev_adapt = 1'b0;
    @(negedge clk);
    err_fit_mag = v.err;
    err_thr     = v.thr;
    start       = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (dpd_adapt) begin
        n_adapt++;
        if (first_adapt == 0) first_adapt = c;
        if (gap > 0 && gap < min_gap) min_gap = gap;
        gap = 0;
      end else if (n_adapt > 0 && busy) begin
        gap++;
      end
      if (!dpd_adapt && prev_adapt && first_fall == 0) first_fall = c;
      prev_adapt = dpd_adapt;
      if (busy) n_busy++;
      if (err_avg_vld) begin
        n_vld++;
        chk($sformatf("v%0d err_avg at vld", idx), err_avg, v.err);
      end
      if (done) begin
        n_done++;
        done_cyc = c;
        chk($sformatf("v%0d iter at done", idx), iter, v.n_iter);
        chk($sformatf("v%0d converged at done", idx), converged, v.conv);
        chk($sformatf("v%0d err_avg at done", idx), err_avg, v.err);
      end
      if (done_cyc != 0 && c >= done_cyc + 3) break;
    end
    chk($sformatf("v%0d done cycle", idx), done_cyc, v.done_cyc);
    chk($sformatf("v%0d done count", idx), n_done, 1);
    chk($sformatf("v%0d first adapt cycle", idx), first_adapt, 1);
    chk($sformatf("v%0d first adapt fall", idx), first_fall, 17);
    chk($sformatf("v%0d adapt cycles", idx), n_adapt, 16 * v.n_iter);
    chk($sformatf("v%0d busy cycles", idx), n_busy, v.done_cyc);
    chk($sformatf("v%0d vld count", idx), n_vld, v.n_iter);
    if (v.n_iter > 1) chk($sformatf("v%0d gap>=4", idx), (min_gap >= 4 && min_gap != 999) ? 1 : 0, 1);
    chk($sformatf("v%0d idle after", idx), busy, 0);
  endtask

  initial begin
    vecs[0] = '{err: 20'd100,     thr: 20'd200,     n_iter: 1, conv: 1, done_cyc: 26};
    vecs[1] = '{err: 20'd500,     thr: 20'd200,     n_iter: 3, conv: 0, done_cyc: 76};
    vecs[2] = '{err: 20'd200,     thr: 20'd200,     n_iter: 1, conv: 1, done_cyc: 26};
    vecs[3] = '{err: 20'd201,     thr: 20'd200,     n_iter: 3, conv: 0, done_cyc: 76};
    vecs[4] = '{err: 20'd0,       thr: 20'd0,       n_iter: 1, conv: 1, done_cyc: 26};
    vecs[5] = '{err: 20'hFFFFF,   thr: 20'hFFFFF,   n_iter: 1, conv: 1, done_cyc: 26};

    rst = 1'b1; start = 1'b0; abort = 1'b0; err_thr = '0; err_fit_mag = '0;
    #12;
    chk("reset busy", busy, 0);
    chk("reset dpd_adapt", dpd_adapt, 0);
    chk("reset outputs", {done, converged, iter, err_avg, err_avg_vld}, 0);
    @(negedge clk); rst = 1'b0;
    begin
      int act = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (busy || dpd_adapt || done || err_avg_vld) act++;
      end
      chk("no activity without start", act, 0);
    end

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Averaging with truncation: (10+20+30+41)>>2 = 25
    @(negedge clk);
    err_fit_mag = '0; err_thr = 20'd30; start = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 25) begin
        chk("avg vld at 25", err_avg_vld, 1);
        chk("avg truncated", err_avg, 25);
      end
      if (c == 26) begin
        chk("avg run done", done, 1);
        chk("avg run converged", converged, 1);
      end
      case (c)
        21: err_fit_mag = 20'd10;
        22: err_fit_mag = 20'd20;
        23: err_fit_mag = 20'd30;
        24: err_fit_mag = 20'd41;
        default: err_fit_mag = 20'd0;
      endcase
    end

    // Abort at cycle 8
    @(negedge clk);
    err_fit_mag = 20'd500; err_thr = 20'd200; start = 1'b1;
    begin
      int n_done = 0, n_busy = 0;
      for (int c = 1; c <= 50; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (c == 8) abort = 1'b1;
        if (c == 9) begin
          abort = 1'b0;
          chk("abort8 dpd_adapt", dpd_adapt, 0);
          chk("abort8 busy", busy, 0);
          chk("abort8 converged", converged, 0);
        end
        if (c >= 9 && busy) n_busy++;
        if (done) n_done++;
      end
      chk("abort8 no done", n_done, 0);
      chk("abort8 stays idle", n_busy, 0);
    end

    run_vec(vecs[0], 10);

    // Abort in the second burst keeps iter and err_avg
    @(negedge clk);
    err_fit_mag = 20'd500; err_thr = 20'd200; start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 30) abort = 1'b1;
      if (c == 31) begin
        abort = 1'b0;
        chk("abort30 busy", busy, 0);
        chk("abort30 iter kept", iter, 1);
        chk("abort30 err_avg kept", err_avg, 500);
      end
    end

    // start pulses while busy are ignored
    @(negedge clk);
    err_fit_mag = 20'd100; err_thr = 20'd200; start = 1'b1;
    begin
      int n_done = 0, done_cyc = 0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        start = (c == 10 || c == 20) ? 1'b1 : 1'b0;
        if (done) begin n_done++; done_cyc = c; end
      end
      chk("busy-start done count", n_done, 1);
      chk("busy-start done cycle", done_cyc, 26);
      chk("busy-start idle", busy, 0);
    end

    // start and abort together in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    begin
      int act = 0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        if (busy || dpd_adapt) act++;
      end
      chk("start+abort stays idle", act, 0);
    end

    // Reset in MEAS of the second iteration (cycles 46..49)
    @(negedge clk);
    err_fit_mag = 20'd500; err_thr = 20'd200; start = 1'b1;
    for (int c = 1; c <= 47; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-reset iter", iter, 1);
    chk("pre-reset busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrun reset busy", busy, 0);
    chk("midrun reset iter", iter, 0);
    chk("midrun reset err_avg", err_avg, 0);
    chk("midrun reset others", {dpd_adapt, done, converged, err_avg_vld}, 0);
    @(negedge clk); rst = 1'b0;
    begin
      int act = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (busy || done) act++;
      end
      chk("post-reset quiet", act, 0);
    end

    run_vec(vecs[1], 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
